// File: rtl/mirror_skolem_stream.sv
// mirror_skolem_stream: streams mirror Skolem pairs (X, Y = X) through a small output FIFO
// Ports: clk, rst (asynchronous, active-high)
//   in_valid_i / in_ready_o / in_x_i        : universal word input stream
//   inj_mask_i                              : fault mask XORed into Y at write time
//   out_valid_o / out_ready_i               : head-entry handshake
//   out_x_o / out_y_o / out_sat_o           : head entry and its formula value
//   pair_cnt_o / err_cnt_o                  : emitted pairs / emitted pairs with out_sat_o = 0
// Option macro MIRROR_CHECK_EN builds mask injection, the checker and err_cnt_o;
// without it Y = X, out_sat_o = 1 and err_cnt_o = 0.
module mirror_skolem_stream #(
   parameter int N     = 10,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [N-1:0] in_x_i,
   input  logic [N-1:0] inj_mask_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [N-1:0] out_x_o,
   output logic [N-1:0] out_y_o,
   output logic         out_sat_o,
   output logic [15:0]  pair_cnt_o,
   output logic [15:0]  err_cnt_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [N-1:0]  x_mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   occ_q, occ_d;
   logic [15:0]   pair_q, pair_d;
   logic          push, pop;
   // in_ready_o depends only on occupancy, so a pop never frees a slot in the same cycle
   assign in_ready_o  = occ_q != FULL;
   assign out_valid_o = occ_q != '0;
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;
   assign occ_d       = push == pop ? occ_q : push ? occ_q + 1'b1 : occ_q - 1'b1;
   assign pair_d      = pair_q + 16'(pop);
   assign out_x_o     = x_mem_q[rd_q];
   assign pair_cnt_o  = pair_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q  <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         pair_q <= '0;
      end else begin
         occ_q  <= occ_d;
         pair_q <= pair_d;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (push) x_mem_q[wr_q] <= in_x_i;
   end
`ifdef MIRROR_CHECK_EN
   logic [N-1:0] y_mem_q [DEPTH];
   logic [15:0]  err_q, err_d;
   always_ff @(posedge clk) begin
      if (push) y_mem_q[wr_q] <= in_x_i ^ inj_mask_i;
   end
   assign out_y_o   = y_mem_q[rd_q];
   // an empty FIFO reports satisfied so out_sat_o comes out of reset as 1
   assign out_sat_o = ~out_valid_o | (&(out_x_o ~^ out_y_o));
   assign err_d     = err_q + 16'(pop & ~out_sat_o);
   assign err_cnt_o = err_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= '0;
      else err_q <= err_d;
   end
`else
   logic unused_mask;
   assign unused_mask = ^inj_mask_i;
   assign out_y_o     = out_x_o;
   assign out_sat_o   = 1'b1;
   assign err_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_mirror_skolem_stream.sv
// tb_mirror_skolem_stream: randomized self-checking bench against a queue-based model
module tb_mirror_skolem_stream;
   localparam int N = 10;
   localparam int DEPTH = 4;
`ifdef MIRROR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_sat;
   logic [N-1:0] in_x, inj_mask, out_x, out_y;
   logic [15:0] pair_cnt, err_cnt;
   int nvec = 0, nerr = 0;
   logic [N-1:0] qx[$], qy[$];
   int m_pair = 0, m_err = 0;
   logic obs_vld, obs_rdy, obs_sat, exp_vld, exp_rdy, exp_sat, did_emit, did_acc;
   logic [N-1:0] obs_x, obs_y, exp_x, exp_y;

   mirror_skolem_stream #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_x_i(in_x),
      .inj_mask_i(inj_mask), .out_valid_o(out_valid), .out_ready_i(out_ready), .out_x_o(out_x),
      .out_y_o(out_y), .out_sat_o(out_sat), .pair_cnt_o(pair_cnt), .err_cnt_o(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drive one cycle, sample DUT at the falling edge, then advance the model past the rising edge
   task automatic tick(input logic v, input logic [N-1:0] x, input logic [N-1:0] m, input logic r);
      in_valid = v; in_x = x; inj_mask = m; out_ready = r;
      @(negedge clk);
      obs_vld = out_valid; obs_rdy = in_ready; obs_x = out_x; obs_y = out_y; obs_sat = out_sat;
      exp_vld = qx.size() != 0;
      exp_rdy = qx.size() != DEPTH;
      exp_x = exp_vld ? qx[0] : '0;
      exp_y = exp_vld ? qy[0] : '0;
      exp_sat = exp_vld ? (exp_x == exp_y) : 1'b1;
      did_acc = v && exp_rdy;
      did_emit = exp_vld && r;
      @(posedge clk);
      #1;
      if (did_emit) begin
         void'(qx.pop_front());
         void'(qy.pop_front());
         m_pair = (m_pair + 1) % 65536;
         if (!exp_sat) m_err = (m_err + 1) % 65536;
      end
      if (did_acc) begin
         qx.push_back(x);
         qy.push_back(CHK ? x ^ m : x);
      end
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      qx.delete(); qy.delete(); m_pair = 0; m_err = 0;
   endtask

   task automatic test_reset();
      nvec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sat !== 1'b1 || pair_cnt !== 16'h0 || err_cnt !== 16'h0) begin
         nerr++;
         $display("FAIL reset_state: vld=%b rdy=%b sat=%b pair=%h err=%h want 0 1 1 0000 0000", out_valid, in_ready, out_sat, pair_cnt, err_cnt);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1, N'($urandom), '0, 1'b0);
      rst = 1'b1;
      #2;
      nvec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || pair_cnt !== 16'h0 || err_cnt !== 16'h0) begin
         nerr++;
         $display("FAIL reset_mid: vld=%b rdy=%b pair=%h err=%h want 0 1 0000 0000", out_valid, in_ready, pair_cnt, err_cnt);
      end
      rst = 1'b0;
      qx.delete(); qy.delete(); m_pair = 0; m_err = 0;
      tick(1'b1, 10'h155, '0, 1'b0);
      tick(1'b0, '0, '0, 1'b1);
      nvec++;
      if (obs_vld !== 1'b1 || obs_x !== 10'h155 || obs_y !== 10'h155 || obs_sat !== 1'b1) begin
         nerr++;
         $display("FAIL reset_reaccept: vld=%b x=%h y=%h sat=%b want 1 155 155 1", obs_vld, obs_x, obs_y, obs_sat);
      end
      nvec++;
      if (pair_cnt !== 16'd1) begin
         nerr++;
         $display("FAIL reset_pair: pair=%0d want 1", pair_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int got;
      do_reset();
      got = 0;
      for (int i = 0; i < 9; i++) begin
         tick(i < 8, N'(i), '0, 1'b1);
         if (obs_vld) begin
            nvec++;
            if (obs_x !== N'(got) || obs_y !== N'(got) || obs_sat !== 1'b1) begin
               nerr++;
               $display("FAIL b2b_word%0d: x=%h y=%h sat=%b want %h %h 1", got, obs_x, obs_y, obs_sat, got, got);
            end
            got++;
         end
      end
      nvec++;
      if (got != 8 || pair_cnt !== 16'd8 || err_cnt !== 16'd0) begin
         nerr++;
         $display("FAIL b2b_counts: emitted=%0d pair=%0d err=%0d want 8 8 0", got, pair_cnt, err_cnt);
      end
   endtask

   task automatic test_full();
      logic [N-1:0] hx, hy;
      do_reset();
      for (int i = 0; i < DEPTH; i++) tick(1'b1, N'($urandom), N'($urandom_range(0, 1) ? $urandom : 0), 1'b0);
      nvec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         nerr++;
         $display("FAIL full_ready: rdy=%b vld=%b want 0 1", in_ready, out_valid);
      end
      hx = out_x; hy = out_y;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, N'($urandom), '0, 1'b0);
         nvec++;
         if (obs_rdy !== 1'b0 || obs_x !== exp_x || obs_y !== exp_y || out_x !== hx || out_y !== hy) begin
            nerr++;
            $display("FAIL full_stable: rdy=%b x=%h y=%h want 0 %h %h", obs_rdy, obs_x, obs_y, exp_x, exp_y);
         end
      end
      for (int i = 0; i < 12; i++) begin
         tick(1'b1, N'($urandom), '0, 1'b1);
         nvec++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld || obs_x !== exp_x || obs_y !== exp_y || obs_sat !== exp_sat) begin
            nerr++;
            $display("FAIL full_drain%0d: rdy=%b vld=%b x=%h y=%h sat=%b want %b %b %h %h %b", i, obs_rdy, obs_vld, obs_x, obs_y, obs_sat, exp_rdy, exp_vld, exp_x, exp_y, exp_sat);
         end
         if (i == 0) begin
            nvec++;
            if (in_ready !== 1'b1) begin
               nerr++;
               $display("FAIL full_reassert: rdy=%b want 1", in_ready);
            end
         end
      end
      nvec++;
      if (pair_cnt !== 16'(m_pair)) begin
         nerr++;
         $display("FAIL full_pair: pair=%0d want %0d", pair_cnt, m_pair);
      end
   endtask

   task automatic test_fault();
      do_reset();
      tick(1'b1, 10'h3FF, 10'h200, 1'b0);
      tick(1'b1, 10'h0AA, 10'h000, 1'b0);
      tick(1'b0, '0, '0, 1'b1);
      nvec++;
      if (obs_x !== 10'h3FF || obs_y !== (CHK ? 10'h1FF : 10'h3FF) || obs_sat !== !CHK) begin
         nerr++;
         $display("FAIL fault_pair: x=%h y=%h sat=%b want 3ff %h %b", obs_x, obs_y, obs_sat, CHK ? 10'h1FF : 10'h3FF, !CHK);
      end
      nvec++;
      if (err_cnt !== 16'(CHK)) begin
         nerr++;
         $display("FAIL fault_err: err=%0d want %0d", err_cnt, CHK);
      end
      tick(1'b0, '0, '0, 1'b1);
      nvec++;
      if (obs_x !== 10'h0AA || obs_y !== 10'h0AA || obs_sat !== 1'b1 || err_cnt !== 16'(CHK)) begin
         nerr++;
         $display("FAIL fault_next: x=%h y=%h sat=%b err=%0d want 0aa 0aa 1 %0d", obs_x, obs_y, obs_sat, err_cnt, CHK);
      end
   endtask

   task automatic test_simul();
      int drained;
      do_reset();
      tick(1'b1, N'($urandom), '0, 1'b0);
      tick(1'b1, N'($urandom), '0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, N'($urandom), '0, 1'b1);
         nvec++;
         if (obs_vld !== 1'b1 || obs_rdy !== 1'b1 || obs_x !== exp_x || obs_y !== exp_y) begin
            nerr++;
            $display("FAIL simul_cycle%0d: vld=%b rdy=%b x=%h y=%h want 1 1 %h %h", i, obs_vld, obs_rdy, obs_x, obs_y, exp_x, exp_y);
         end
      end
      nvec++;
      if (pair_cnt !== 16'd5) begin
         nerr++;
         $display("FAIL simul_pair: pair=%0d want 5", pair_cnt);
      end
      drained = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, '0, '0, 1'b1);
         if (obs_vld) begin
            drained++;
            nvec++;
            if (obs_x !== exp_x) begin
               nerr++;
               $display("FAIL simul_drain: x=%h want %h", obs_x, exp_x);
            end
         end
      end
      nvec++;
      if (drained != 2) begin
         nerr++;
         $display("FAIL simul_occ: drained=%0d want 2", drained);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] m;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         tick(1'($urandom_range(0, 2) != 0), N'($urandom), m, 1'($urandom_range(0, 2) != 0));
         nvec++;
         if (obs_rdy !== exp_rdy || obs_vld !== exp_vld || obs_sat !== exp_sat || (exp_vld && (obs_x !== exp_x || obs_y !== exp_y))) begin
            nerr++;
            $display("FAIL rand_cycle%0d: rdy=%b vld=%b x=%h y=%h sat=%b want %b %b %h %h %b", i, obs_rdy, obs_vld, obs_x, obs_y, obs_sat, exp_rdy, exp_vld, exp_x, exp_y, exp_sat);
         end
         nvec++;
         if (pair_cnt !== 16'(m_pair) || err_cnt !== 16'(m_err)) begin
            nerr++;
            $display("FAIL rand_cnt%0d: pair=%0d err=%0d want %0d %0d", i, pair_cnt, err_cnt, m_pair, m_err);
         end
      end
   endtask

   task automatic test_wrap();
      int emits;
      do_reset();
      emits = 0;
      for (int i = 0; i < 70000 && emits < 65536; i++) begin
         tick(1'b1, N'(i), '0, 1'b1);
         if (did_emit) emits++;
         if (emits == 65535 && did_emit) begin
            nvec++;
            if (pair_cnt !== 16'hFFFF) begin
               nerr++;
               $display("FAIL wrap_pre: pair=%h want ffff", pair_cnt);
            end
         end
      end
      nvec++;
      if (emits != 65536 || pair_cnt !== 16'h0000 || err_cnt !== 16'h0000) begin
         nerr++;
         $display("FAIL wrap: emits=%0d pair=%h err=%h want 65536 0000 0000", emits, pair_cnt, err_cnt);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_x = '0; inj_mask = '0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_full();
      test_fault();
      test_simul();
      test_random();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
